// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller: reset vector default
// and the redirect FSM state encoding.
package pc_fetch_ctrl_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'hBFC0_0000;
    localparam int          PC_W             = 32;

    typedef enum logic {
        NORM = 1'b0,
        PEND = 1'b1
    } fetch_state_e;

    // Sequential fetch increment; wraps modulo 2^32.
    function automatic logic [PC_W-1:0] pc_inc4(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_flopenr.sv
// Enable flop with synchronous active-high reset to a parameterised value.
module pc_fetch_ctrl_flopenr #(
    parameter int          W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset wins over enable; otherwise load d when enabled.
    always_ff @(posedge clk) begin
        if (rst)     q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC register and next-PC selector with delay-slot redirects,
// buffering of redirects that arrive while the instruction port stalls fetch,
// and absolute-priority exception redirects.
// Optional branch statistics counters: define PC_FETCH_BRANCH_STAT_EN.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_exc,
    input  logic [31:0]      exc_pc,
    input  logic             branch_d,
    input  logic             branch_taken_d,
    input  logic [31:0]      branch_target_d,
    input  logic             jump_d,
    input  logic [31:0]      jump_target_d,
    output logic [31:0]      pc_f,
    output logic [31:0]      pc_plus4_f,
    output logic             redirect_pend,
    output logic [CNT_W-1:0] br_total_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;
    logic         pc_en, pend_en;
    logic         acc;
    logic [31:0]  tgt;

    // A jump outranks a conditional branch if both are flagged in D.
    assign acc = ~stall_d & ~flush_exc & (jump_d | (branch_d & branch_taken_d));
    assign tgt = jump_d ? jump_target_d : branch_target_d;

    // Next-PC priority: exception, buffered redirect, live redirect,
    // capture under stall, sequential, hold.
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        pc_d       = pc_inc4(pc_q);
        pend_en    = 1'b0;
        pend_tgt_d = tgt;
        if (flush_exc) begin
            pc_en   = 1'b1;
            pc_d    = exc_pc;
            state_d = NORM;
        end else if (state_q == PEND && !stall_f) begin
            // Any acc here is a protocol error and is dropped.
            pc_en   = 1'b1;
            pc_d    = pend_tgt_q;
            state_d = NORM;
        end else if (acc && !stall_f) begin
            pc_en   = 1'b1;
            pc_d    = tgt;
            state_d = NORM;
        end else if (acc && stall_f) begin
            // Latest accepted target wins while still stalled.
            pend_en = 1'b1;
            state_d = PEND;
        end else if (!stall_f) begin
            pc_en = 1'b1;
        end
    end

    // Redirect FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= NORM;
        else     state_q <= state_d;
    end

    pc_fetch_ctrl_flopenr #(.W(32), .RST_VAL(RESET_PC)) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_d),
        .q   (pc_q)
    );

    pc_fetch_ctrl_flopenr #(.W(32), .RST_VAL(32'h0)) u_pend_tgt_reg (
        .clk (clk),
        .rst (rst),
        .en  (pend_en),
        .d   (pend_tgt_d),
        .q   (pend_tgt_q)
    );

    assign pc_f          = pc_q;
    assign pc_plus4_f    = pc_inc4(pc_q);
    assign redirect_pend = (state_q == PEND);

`ifdef PC_FETCH_BRANCH_STAT_EN
    logic [CNT_W-1:0] br_total_q, br_total_d;
    logic [CNT_W-1:0] br_taken_q, br_taken_d;
    logic             br_acc;

    // Count every conditional branch D hands over, and the taken subset.
    assign br_acc = ~stall_d & ~flush_exc & branch_d;

    always_comb begin
        br_total_d = br_total_q;
        br_taken_d = br_taken_q;
        if (br_acc) begin
            br_total_d = br_total_q + 1'b1;
            if (branch_taken_d) br_taken_d = br_taken_q + 1'b1;
        end
    end

    // Statistics counter registers; wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_total_q <= '0;
            br_taken_q <= '0;
        end else begin
            br_total_q <= br_total_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign br_total_cnt = br_total_q;
    assign br_taken_cnt = br_taken_q;
`else
    assign br_total_cnt = '0;
    assign br_taken_cnt = '0;
`endif

endmodule
